ms_master: RTL and testbench

- Initiator end of the simple master/slave register-write interface.
- Accepts write commands (addr, data) from local logic into a small command FIFO and issues them to the responder one at a time.
- Bus rule: the responder writes the data bus into the register addressed by the previous cycle's address bus.
- Address and data changes are therefore staggered: address phase first, then data phase. The master holds data while the responder's sready is low.

---
 rtl/ms_master.sv | 176 +++++++++++++++++
 tb/tb_ms_master.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ms_master.sv
// ms_master: initiator of the staggered address/data register-write bus, fed by a small command FIFO.
// Optional transfer/stall statistics counters are compiled in when MS_MASTER_STATS_EN is defined.
`default_nettype none

module ms_master #(
  parameter int AW            = 2,
  parameter int DW            = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int STALL_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  input  logic          sready,
  output logic          busy,
  output logic          done,
  output logic          err
`ifdef MS_MASTER_STATS_EN
  ,
  output logic [15:0]   xfer_cnt,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;

  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  // Command FIFO
  logic [AW-1:0] mem_addr [FIFO_DEPTH];
  logic [DW-1:0] mem_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // FSM and datapath
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [DW-1:0] hold_data;
  logic [SW-1:0] stall;
  logic [SW-1:0] stall_nxt;
  logic [AW-1:0] addr_nxt;
  logic [DW-1:0] data_nxt;
  logic          done_nxt;
  logic          err_nxt;
  logic          stall_expired;

  assign full          = (count == FULL_CNT);
  assign empty         = (count == '0);
  assign cmd_ready     = ~full;
  assign push          = cmd_valid & cmd_ready;
  assign busy          = ~empty | (state != S_IDLE);
  assign stall_expired = (stall == STALL_LAST);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= cmd_addr;
      mem_data[wr_ptr] <= cmd_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_ADDR;
      S_ADDR:  state_nxt = S_DATA;
      S_DATA:  if (sready || stall_expired) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address moves only when leaving IDLE and data only when leaving ADDR,
  // so the two bus fields never change on the same edge.
  always_comb begin
    pop       = 1'b0;
    addr_nxt  = addr;
    data_nxt  = data;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    stall_nxt = stall;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          addr_nxt = mem_addr[rd_ptr];
        end
      end
      S_ADDR: data_nxt = hold_data;
      S_DATA: begin
        if (sready) begin
          done_nxt  = 1'b1;
          stall_nxt = '0;
        end else if (stall_expired) begin
          err_nxt   = 1'b1;
          stall_nxt = '0;
        end else begin
          stall_nxt = stall + 1'b1;
        end
      end
      default: stall_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr      <= '0;
      data      <= '0;
      hold_data <= '0;
      stall     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      addr  <= addr_nxt;
      data  <= data_nxt;
      stall <= stall_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
      if (pop) hold_data <= mem_data[rd_ptr];
    end
  end

`ifdef MS_MASTER_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (done && (xfer_cnt != 16'hFFFF))
        xfer_cnt <= xfer_cnt + 16'd1;
      if ((state == S_DATA) && !sready && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ms_master.sv
// tb_ms_master: directed self-checking bench for ms_master with a behavioural responder.
`timescale 1ns/1ps
`default_nettype none

module tb_ms_master;
  logic       clk = 1'b0;
  logic       rstn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_data;
  logic [1:0] addr;
  logic [7:0] data;
  logic       sready;
  logic       busy;
  logic       done;
  logic       err;
`ifdef MS_MASTER_STATS_EN
  logic [15:0] xfer_cnt;
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ms_master #(.AW(2), .DW(8), .FIFO_DEPTH(4), .STALL_TIMEOUT(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .addr      (addr),
    .data      (data),
    .sready    (sready),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef MS_MASTER_STATS_EN
    ,
    .xfer_cnt  (xfer_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // Responder: writes the data bus into the register selected by last cycle's address.
  logic [7:0] regs [4];
  logic [1:0] addr_q;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
      addr_q <= 2'd0;
    end else begin
      regs[addr_q] <= data;
      addr_q       <= addr;
    end
  end

  // Event monitor on the falling edge
  int         cyc = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         toggle_both = 0;
  int         done_cyc[$];
  logic [1:0] addr_prev = 2'd0;
  logic [7:0] data_prev = 8'd0;
  always @(negedge clk) begin
    cyc++;
    if (done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
    if (err) err_cnt++;
    if ((addr !== addr_prev) && (data !== data_prev)) toggle_both++;
    addr_prev = addr;
    data_prev = data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] a, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while ((done_cnt < target) && (n < budget)) begin
      tick();
      n++;
    end
    chk(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  int base_d, base_e, base_t, base_q;
  logic early_err;

  initial begin
    rstn = 1'b0; cmd_valid = 1'b0; cmd_addr = 2'd0; cmd_data = 8'd0; sready = 1'b1;
    tick(); tick();
    chk("reset_addr", 32'(addr), 32'd0);
    chk("reset_data", 32'(data), 32'd0);
    chk("reset_done_err", 32'({done, err}), 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    tick();

    // Single write
    push(2'd2, 8'h5A);
    tick();
    chk("single_addr_phase", 32'({addr, data}), 32'({2'd2, 8'h00}));
    tick();
    chk("single_data_phase", 32'({addr, data, done}), 32'({2'd2, 8'h5A, 1'b0}));
    tick();
    chk("single_done", 32'(done), 32'd1);
    chk("single_reg_c", 32'(regs[2]), 32'h5A);
    chk("single_idle", 32'(busy), 32'd0);

    // Back-to-back
    base_d = done_cnt; base_t = toggle_both; base_q = done_cyc.size();
    push(2'd0, 8'h11); push(2'd1, 8'h22); push(2'd2, 8'h33); push(2'd3, 8'h44);
    wait_done("b2b_four_done", base_d + 4, 30);
    tick();
    for (int k = 1; k < 4; k++)
      chk("b2b_spacing", 32'(done_cyc[base_q + k] - done_cyc[base_q + k - 1]), 32'd3);
    chk("b2b_regs", {regs[0], regs[1], regs[2], regs[3]}, 32'h11223344);
    chk("b2b_no_same_edge", 32'(toggle_both - base_t), 32'd0);

    // Stall for three DATA cycles
    sready = 1'b0;
    base_d = done_cnt; base_e = err_cnt;
    push(2'd3, 8'h03);
    tick(); tick();
    chk("stall_entry", 32'({addr, data}), 32'({2'd3, 8'h03}));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold", 32'({done, err, addr, data}), 32'({2'b00, 2'd3, 8'h03}));
    end
    sready = 1'b1;
    tick();
    chk("stall_done", 32'(done), 32'd1);
    tick(); tick(); tick();
    chk("stall_done_once", 32'(done_cnt - base_d), 32'd1);
    chk("stall_no_err", 32'(err_cnt - base_e), 32'd0);

    // Timeout with sready stuck low
    sready = 1'b0;
    base_d = done_cnt; early_err = 1'b0;
    push(2'd1, 8'hA5);
    for (int k = 0; k < 17; k++) begin
      tick();
      if (err) early_err = 1'b1;
    end
    chk("timeout_not_early", 32'(early_err), 32'd0);
    tick();
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_no_done", 32'(done_cnt - base_d), 32'd0);
    chk("timeout_idle", 32'(busy), 32'd0);
    sready = 1'b1;
    base_d = done_cnt;
    push(2'd2, 8'h66);
    wait_done("after_timeout_done", base_d + 1, 10);
    tick();
    chk("after_timeout_reg", 32'(regs[2]), 32'h66);

    // Reset during DATA with two queued entries
    sready = 1'b0;
    base_d = done_cnt;
    push(2'd0, 8'hB1); push(2'd1, 8'hB2); push(2'd2, 8'hB3);
    rstn = 1'b0;
    #1;
    chk("rst_mid_bus", 32'({addr, data, busy, done}), 32'd0);
    tick(); tick();
    rstn = 1'b1;
    sready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("rst_mid_no_done", 32'(done_cnt - base_d), 32'd0);
    chk("rst_mid_ready_idle", 32'({cmd_ready, busy}), 32'({1'b1, 1'b0}));
    chk("rst_mid_dropped", 32'(regs[1]), 32'h00);

    // Full FIFO with push attempted during pop
    sready = 1'b0;
    base_d = done_cnt;
    push(2'd3, 8'hC0);
    push(2'd0, 8'hD0); push(2'd1, 8'hD1); push(2'd2, 8'hD2); push(2'd3, 8'hD3);
    chk("full_ready_low", 32'({cmd_ready, busy}), 32'({1'b0, 1'b1}));
    cmd_valid = 1'b1; cmd_addr = 2'd0; cmd_data = 8'hEE;
    sready = 1'b1;
    tick();
    chk("full_first_done", 32'({done, cmd_ready}), 32'({1'b1, 1'b0}));
    tick();
    chk("full_after_pop_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0;
    wait_done("full_all_done", base_d + 5, 40);
    for (int k = 0; k < 6; k++) tick();
    chk("full_done_count", 32'(done_cnt - base_d), 32'd5);
    chk("full_regs", {regs[0], regs[1], regs[2], regs[3]}, 32'hD0D1D2D3);
    chk("full_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
